fetch_unit: RTL and testbench

Instruction-fetch stage that drives the program counter into the instruction memory and consumes its word-addressed `Instruction`, `branch` and `jump` outputs. It registers each fetched word into an IF/ID slot with a valid/ready handshake toward decode. Jumps redirect immediately; conditional branches wait for the resolution pulse from execute. With the configuration macro defined, branches are instead statically predicted.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/branch_target_calc.sv | 21 ++
 rtl/fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, opcode helper and the state type for fetch_unit.
// The state set depends on FETCH_BRANCH_PREDICT_EN: the default build has
// FETCH/WAIT_BR, the predicting build has FETCH/SPEC/SPEC_STALL.
package fetch_pkg;

  localparam logic [5:0]  OP_JUMP     = 6'b000001;
  localparam logic [5:0]  OP_BR_FIRST = 6'b100000;
  localparam logic [5:0]  OP_BR_LAST  = 6'b100011;
  localparam logic [31:0] NOP_WORD    = 32'h0;

`ifdef FETCH_BRANCH_PREDICT_EN
  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    SPEC       = 2'd1,
    SPEC_STALL = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    WAIT_BR = 1'b1
  } fetch_state_t;
`endif

  // True for the conditional-branch opcode range.
  function automatic logic is_branch_op(input logic [5:0] op);
    return (op >= OP_BR_FIRST) && (op <= OP_BR_LAST);
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: combinational redirect target, tgt = pc + 1 + sext(imm),
// modulo 2^PC_W. Shared by the jump and branch paths of fetch_unit.
// Ports:
//   pc  in  PC_W  current fetch address
//   imm in  16    instruction[15:0], two's-complement word offset
//   tgt out PC_W  redirect target
module branch_target_calc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  output logic [PC_W-1:0] tgt
);

  logic [PC_W-1:0] imm_ext;

  // A size cast of a signed operand sign-extends for any PC_W >= 16.
  assign imm_ext = PC_W'(signed'(imm));
  assign tgt     = pc + PC_W'(1) + imm_ext;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Drives pc to the instruction memory,
// captures the returned word into an IF/ID slot with a valid/ready handshake,
// redirects immediately on jumps and handles conditional branches either by
// stalling until execute resolves them (default) or, with the macro
// FETCH_BRANCH_PREDICT_EN defined, by static backward-taken/forward-not-taken
// prediction with a registered flush pulse on mispredict.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   pc                      fetch address to instruction memory
//   instruction/branch/jump word and its memory-side decode for pc
//   id_valid/id_ready       IF/ID slot handshake toward decode
//   id_instr/id_pc          registered instruction and its address
//   br_resolve/br_taken     branch resolution pulse and outcome from execute
//   flush                   kill younger instructions (0 unless macro build)
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     instruction,
  input  logic            branch,
  input  logic            jump,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  input  logic            br_resolve,
  input  logic            br_taken,
  output logic            flush
);
  import fetch_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  // Default build: saved taken target. Predict build: the path not predicted.
  logic [PC_W-1:0] redirect_reg, redirect_next;
  logic            id_valid_reg, id_valid_next;
  logic [31:0]     id_instr_reg, id_instr_next;
  logic [PC_W-1:0] id_pc_reg, id_pc_next;

  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pc_inc;
  logic            is_branch;
  logic            fetch_ok;
  logic            cap;
  logic            slot_write;

`ifdef FETCH_BRANCH_PREDICT_EN
  logic pred_reg, pred_next;
  logic flush_reg;
  logic mispredict;
`endif

  branch_target_calc #(.PC_W(PC_W)) u_tgt (
    .pc  (pc_reg),
    .imm (instruction[15:0]),
    .tgt (tgt)
  );

  assign pc_inc    = pc_reg + PC_W'(1);
  // jump wins if memory ever flags both
  assign is_branch = branch && !jump;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    redirect_next = redirect_reg;
    fetch_ok      = 1'b0;
`ifdef FETCH_BRANCH_PREDICT_EN
    pred_next     = pred_reg;
    mispredict    = 1'b0;
`endif

    case (state_reg)
      FETCH:      fetch_ok = 1'b1;
`ifdef FETCH_BRANCH_PREDICT_EN
      // Only one branch may be in flight; a second one waits at pc.
      SPEC:       fetch_ok = !is_branch;
      SPEC_STALL: fetch_ok = 1'b0;
`else
      WAIT_BR:    fetch_ok = 1'b0;
`endif
      default:    fetch_ok = 1'b0;
    endcase

    cap = fetch_ok && (!id_valid_reg || id_ready);

    if (cap) begin
      if (jump) begin
        pc_next = tgt;
      end else if (is_branch) begin
`ifdef FETCH_BRANCH_PREDICT_EN
        // Negative offset (bit 15) means a backward branch: predict taken.
        if (instruction[15]) begin
          pc_next       = tgt;
          redirect_next = pc_inc;
          pred_next     = 1'b1;
        end else begin
          pc_next       = pc_inc;
          redirect_next = tgt;
          pred_next     = 1'b0;
        end
        state_next = SPEC;
`else
        pc_next       = pc_inc;
        redirect_next = tgt;
        state_next    = WAIT_BR;
`endif
      end else begin
        pc_next = pc_inc;
      end
    end

`ifdef FETCH_BRANCH_PREDICT_EN
    if ((state_reg == SPEC || state_reg == SPEC_STALL) && br_resolve) begin
      state_next = FETCH;
      if (br_taken != pred_reg) begin
        // Wrong path: restart at the other path, discarding this cycle's cap.
        mispredict = 1'b1;
        pc_next    = redirect_reg;
      end
    end else if (state_reg == SPEC && is_branch) begin
      state_next = SPEC_STALL;
    end
`else
    // pc already sits at branch+1, so only a taken outcome moves it.
    if (state_reg == WAIT_BR && br_resolve) begin
      if (br_taken) begin
        pc_next = redirect_reg;
      end
      state_next = FETCH;
    end
`endif
  end

`ifdef FETCH_BRANCH_PREDICT_EN
  assign slot_write = cap && !mispredict;
`else
  assign slot_write = cap;
`endif

  always_comb begin
    id_valid_next = id_valid_reg;
    id_instr_next = id_instr_reg;
    id_pc_next    = id_pc_reg;
    if (slot_write) begin
      id_valid_next = 1'b1;
      id_instr_next = instruction;
      id_pc_next    = pc_reg;
    end else if (id_valid_reg && id_ready) begin
      id_valid_next = 1'b0;
    end
`ifdef FETCH_BRANCH_PREDICT_EN
    if (mispredict) begin
      id_valid_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      redirect_reg <= '0;
      id_valid_reg <= 1'b0;
      id_instr_reg <= NOP_WORD;
      id_pc_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      redirect_reg <= redirect_next;
      id_valid_reg <= id_valid_next;
      id_instr_reg <= id_instr_next;
      id_pc_reg    <= id_pc_next;
    end
  end

`ifdef FETCH_BRANCH_PREDICT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_reg  <= 1'b0;
      flush_reg <= 1'b0;
    end else begin
      pred_reg  <= pred_next;
      flush_reg <= mispredict;
    end
  end

  assign flush = flush_reg;
`else
  assign flush = 1'b0;
`endif

  assign pc       = pc_reg;
  assign id_valid = id_valid_reg;
  assign id_instr = id_instr_reg;
  assign id_pc    = id_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an
// architectural program-order model. Expected (pc, word) pairs are queued when
// a phase starts; a monitor pops them as decode accepts the slot, holding back
// instructions fetched under an unresolved branch until its outcome is known.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [PC_W-1:0] pc;
  logic [31:0]     instruction;
  logic            branch;
  logic            jump;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic            br_resolve;
  logic            br_taken;
  logic            flush;

  logic [31:0] mem [64];
  txn_t        exp_q[$];
  txn_t        spec_buf[$];
  bit          out_q[$];

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int res_delay = 3;
  bit rand_ready = 1'b0;
  bit exec_busy = 1'b0;

  always #5 clk = ~clk;

  assign instruction = mem[pc[5:0]];
  assign jump        = (instruction[31:26] == OP_JUMP);
  assign branch      = is_branch_op(instruction[31:26]);

  fetch_unit #(.PC_W(PC_W), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .branch      (branch),
    .jump        (jump),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .flush       (flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic sb_compare(input logic [31:0] a, input logic [31:0] w);
    txn_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got id_pc %0h, nothing expected", a);
    end else begin
      e = exp_q.pop_front();
      chk("sb_id_pc", a, e.a);
      chk("sb_id_instr", w, e.w);
      $display("accept pc=%0h instr=%08h", a, w);
    end
  endtask

  // Architectural walk of the program in memory; forced<0 picks outcomes at random.
  function automatic void build_expect(input int forced);
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] t;
    txn_t        e;
    bit          tk;
    exp_q.delete();
    out_q.delete();
    a = 32'h0;
    for (int i = 0; i < 4000; i++) begin
      w   = mem[a[5:0]];
      e.a = a;
      e.w = w;
      exp_q.push_back(e);
      t = a + 32'd1 + {{16{w[15]}}, w[15:0]};
      if (w[31:26] == OP_JUMP) begin
        a = t;
      end else if (is_branch_op(w[31:26])) begin
        tk = (forced < 0) ? bit'($urandom_range(0, 1)) : (forced != 0);
        out_q.push_back(tk);
        a = tk ? t : a + 32'd1;
      end else begin
        a = a + 32'd1;
      end
    end
  endfunction

  task automatic fill_nops();
    for (int i = 0; i < 64; i++) mem[i] = NOP_WORD;
  endtask

  task automatic fill_random();
    int          r;
    int          v;
    logic [5:0]  op;
    logic [15:0] imm;
    for (int i = 0; i < 64; i++) begin
      r   = $urandom_range(0, 99);
      v   = $urandom_range(0, 40) - 20;
      imm = v[15:0];
      if (r < 15)      op = OP_JUMP;
      else if (r < 35) op = OP_BR_FIRST + 6'($urandom_range(0, 3));
      else             op = 6'($urandom_range(2, 31));
      mem[i] = (r >= 95) ? NOP_WORD : {op, 10'($urandom), imm};
    end
  endtask

  task automatic do_reset(input int forced);
    @(posedge clk);
    #1 rst_n = 1'b0;
    id_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    build_expect(forced);
    @(negedge clk);
    chk("rst_pc_2", pc, 32'h0);
    chk("rst_id_valid_2", 32'(id_valid), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idpc(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (id_valid && id_pc == a) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idpc: id_pc never reached %0h", a);
    end
  endtask

  task automatic wait_resolve();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (br_resolve) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_resolve: no br_resolve pulse seen");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!exec_busy) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: branch resolution still in progress");
    end
  endtask

  // Execute model: resolves each branch accepted by decode after a delay.
  initial begin : execute
    int d;
    bit tk;
    br_resolve = 1'b0;
    br_taken   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && id_ready && is_branch_op(id_instr[31:26])) begin
        exec_busy = 1'b1;
        tk = 1'b0;
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_outcome: no outcome for branch at %0h", id_pc);
        end else begin
          tk = out_q.pop_front();
        end
        d = (res_delay < 0) ? $urandom_range(0, 4) : res_delay;
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 br_resolve = 1'b1;
        br_taken = tk;
        @(posedge clk);
        #1 br_resolve = 1'b0;
        br_taken = 1'($urandom_range(0, 1));
        exec_busy = 1'b0;
      end
    end
  end

  // Monitor: checks accepted slots and flush against the model.
  initial begin : monitor
    bit   br_open;
    bit   resolving;
    bit   flush_exp;
`ifdef FETCH_BRANCH_PREDICT_EN
    bit   br_pred;
    br_pred = 1'b0;
`endif
    txn_t t;
    br_open   = 1'b0;
    resolving = 1'b0;
    flush_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        br_open   = 1'b0;
        resolving = 1'b0;
        spec_buf.delete();
      end else begin
        chk("flush", 32'(flush), resolving ? 32'(flush_exp) : 32'h0);
        if (resolving) begin
          if (!flush_exp) begin
            while (spec_buf.size() > 0) begin
              t = spec_buf.pop_front();
              sb_compare(t.a, t.w);
            end
          end
          spec_buf.delete();
          resolving = 1'b0;
          br_open   = 1'b0;
        end
        if (id_valid && id_ready) begin
          accepted++;
          if (br_open) begin
            t.a = id_pc;
            t.w = id_instr;
            spec_buf.push_back(t);
          end else begin
            sb_compare(id_pc, id_instr);
            if (is_branch_op(id_instr[31:26])) begin
              br_open = 1'b1;
`ifdef FETCH_BRANCH_PREDICT_EN
              br_pred = id_instr[15];
`endif
            end
          end
        end
        if (br_resolve && br_open) begin
          resolving = 1'b1;
`ifdef FETCH_BRANCH_PREDICT_EN
          flush_exp = (br_taken != br_pred);
`else
          flush_exp = 1'b0;
`endif
        end
      end
    end
  end

  initial begin
    if (rand_ready) id_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 if (rand_ready) id_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    int acc0;
    id_ready = 1'b1;

    // Sequential fetch, backpressure and a jump back to 0.
    fill_nops();
    mem[21] = 32'h07FFFFEA;
    res_delay = 3;
    do_reset(1);
    wait_idpc(32'd4);
    chk("bp_pre_pc", pc, 32'd5);
    @(posedge clk);
    #1 id_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 32'(id_valid), 32'h1);
      chk("bp_id_pc", id_pc, 32'd5);
      chk("bp_instr", id_instr, mem[5]);
      chk("bp_pc", pc, 32'd6);
    end
    @(posedge clk);
    #1 id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_id_pc", id_pc, 32'd6);
    wait_idpc(32'd21);
    chk("jump_pc", pc, 32'h0);
    @(negedge clk);
    chk("jump_nobubble_valid", 32'(id_valid), 32'h1);
    chk("jump_nobubble_id_pc", id_pc, 32'h0);

    // Backward branch at 19 with offset -4.
    wait_idle();
    fill_nops();
    mem[19] = 32'h8400FFFC;
`ifdef FETCH_BRANCH_PREDICT_EN
    do_reset(0);
    wait_idpc(32'd19);
    chk("bw_pred_pc", pc, 32'd16);
    wait_resolve();
    @(negedge clk);
    chk("bw_flush", 32'(flush), 32'h1);
    chk("bw_flush_valid", 32'(id_valid), 32'h0);
    chk("bw_flush_pc", pc, 32'd20);
`else
    do_reset(1);
    wait_idpc(32'd19);
    chk("br_pc_hold", pc, 32'd20);
    @(negedge clk);
    chk("br_valid_drop", 32'(id_valid), 32'h0);
    chk("br_pc_wait", pc, 32'd20);
    wait_resolve();
    @(negedge clk);
    chk("br_taken_pc", pc, 32'd16);
`endif

    // Forward branch at 10 with offset +10, taken then not taken.
    wait_idle();
    fill_nops();
    mem[10] = 32'h8C00000A;
    do_reset(1);
    wait_idpc(32'd10);
    chk("fw_pc_after_cap", pc, 32'd11);
    wait_resolve();
    @(negedge clk);
    chk("fw_taken_pc", pc, 32'd21);
`ifdef FETCH_BRANCH_PREDICT_EN
    chk("fw_taken_flush", 32'(flush), 32'h1);
`endif
    wait_idle();
    do_reset(0);
    wait_idpc(32'd10);
    chk("fw_nt_pc_after_cap", pc, 32'd11);
    wait_resolve();
    @(negedge clk);
`ifdef FETCH_BRANCH_PREDICT_EN
    chk("fw_nt_flush", 32'(flush), 32'h0);
`else
    chk("fw_nt_pc", pc, 32'd11);
`endif

    // Random program, random backpressure and resolution delays.
    wait_idle();
    fill_random();
    res_delay = -1;
    do_reset(-1);
    acc0 = accepted;
    rand_ready = 1'b1;
    repeat (3000) @(posedge clk);
    rand_ready = 1'b0;
    #1 id_ready = 1'b1;
    wait_idle();
    checks++;
    if (accepted - acc0 < 300) begin
      errors++;
      $display("FAIL rand_progress: accepted %0d, required at least 300", accepted - acc0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
